// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs a req/ack handshake with variable-latency imem, strobes the fetched word to IR.
// Latency: fetch_en->imem_req 1 cycle, ack->instr_valid 1 cycle; imem_req held until ack or timeout.
module instr_fetch_unit #(
    parameter int unsigned         ADDR_W   = 16,
    parameter int unsigned         INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = 16'h0000,
    parameter int unsigned         PC_STEP  = 1,
    parameter int unsigned         TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               instr_valid,
    output logic               busy,
    output logic               fetch_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  pcout_q, pcout_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pcout_d = pcout_q;
        valid_d = 1'b0;
        err_d   = err_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (redirect) pc_d = redirect_pc;
                if (fetch_en) begin
                    state_d = WAIT;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (redirect) pc_d = redirect_pc;
                if (imem_ack) begin
                    // A redirect in the ack cycle kills the response just like an earlier one.
                    if (!drop_q && !redirect) begin
                        ir_d    = imem_rdata;
                        pcout_d = addr_q;
                        pc_d    = addr_q + ADDR_W'(PC_STEP);
                        valid_d = 1'b1;
                    end
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (redirect) drop_d = 1'b1;
                    if (cnt_q >= CNT_LAST) begin
                        err_d   = 1'b1;
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Address is frozen only while a request stays outstanding; otherwise it follows the PC.
        addr_d = (state_q == WAIT && state_d == WAIT) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ir_q    <= '0;
            pcout_q <= RESET_PC;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = (state_q == WAIT);
    assign busy        = (state_q == WAIT);
    assign imem_addr   = addr_q;
    assign ir_out      = ir_q;
    assign pc_out      = pcout_q;
    assign pc_next     = pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, redirect, imem_ack;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, instr_valid, busy, fetch_err;
    logic [15:0] imem_addr, ir_out, pc_out, pc_next;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir_out      (ir_out),
        .pc_out      (pc_out),
        .pc_next     (pc_next),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        fetch_en = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   imem_req,    0);
        check({tag, "_addr"},  imem_addr,   16'h0000);
        check({tag, "_ir"},    ir_out,      16'h0000);
        check({tag, "_pcout"}, pc_out,      16'h0000);
        check({tag, "_pcnxt"}, pc_next,     16'h0000);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_busy"},  busy,        0);
        check({tag, "_err"},   fetch_err,   0);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 0; redirect = 0; imem_ack = 0;
        redirect_pc = 16'h0; imem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();
        check_reset_vals("rst");

        // Basic fetch, ack two cycles after request
        fetch_en = 1;
        step();
        check("f1_req", imem_req, 1);
        check("f1_busy", busy, 1);
        check("f1_addr", imem_addr, 16'h0000);
        step();
        check("f1_addr_hold", imem_addr, 16'h0000);
        check("f1_novalid", instr_valid, 0);
        step();
        imem_ack = 1; imem_rdata = 16'hA123;
        step();
        check("f1_valid", instr_valid, 1);
        check("f1_ir", ir_out, 16'hA123);
        check("f1_pcout", pc_out, 16'h0000);
        check("f1_pcnxt", pc_next, 16'h0001);
        check("f1_busy_lo", busy, 0);
        check("f1_req_lo", imem_req, 0);
        step();
        check("f1_valid_1cyc", instr_valid, 0);

        // Redirect with fetch_en in the same IDLE cycle
        redirect = 1; redirect_pc = 16'h0040; fetch_en = 1;
        step();
        check("f2_addr", imem_addr, 16'h0040);
        check("f2_req", imem_req, 1);
        imem_ack = 1; imem_rdata = 16'h5555;
        step();
        check("f2_valid", instr_valid, 1);
        check("f2_ir", ir_out, 16'h5555);
        check("f2_pcout", pc_out, 16'h0040);
        check("f2_pcnxt", pc_next, 16'h0041);

        // Back-to-back: fetch_en while instr_valid is high; then redirect in WAIT drops the response
        fetch_en = 1;
        step();
        check("f3_addr", imem_addr, 16'h0041);
        redirect = 1; redirect_pc = 16'h0100;
        step();
        check("f3_pcnxt_redir", pc_next, 16'h0100);
        check("f3_addr_frozen", imem_addr, 16'h0041);
        check("f3_req_held", imem_req, 1);
        imem_ack = 1; imem_rdata = 16'hDEAD;
        step();
        check("f3_novalid", instr_valid, 0);
        check("f3_ir_keep", ir_out, 16'h5555);
        check("f3_pcout_keep", pc_out, 16'h0040);
        check("f3_pcnxt", pc_next, 16'h0100);
        check("f3_idle", busy, 0);
        fetch_en = 1;
        step();
        check("f3_next_addr", imem_addr, 16'h0100);
        imem_ack = 1; imem_rdata = 16'h7777;
        step();
        check("f3_next_valid", instr_valid, 1);
        check("f3_next_ir", ir_out, 16'h7777);
        check("f3_next_pcout", pc_out, 16'h0100);

        // Redirect to FFFF, then wrap
        redirect = 1; redirect_pc = 16'hFFFF;
        step();
        check("f4_pcnxt", pc_next, 16'hFFFF);
        check("f4_idle", busy, 0);
        check("f4_addr_track", imem_addr, 16'hFFFF);
        fetch_en = 1;
        step();
        imem_ack = 1; imem_rdata = 16'h1111;
        step();
        check("f4_ir", ir_out, 16'h1111);
        check("f4_pcout", pc_out, 16'hFFFF);
        check("f4_pcnxt_wrap", pc_next, 16'h0000);

        // Redirect and ack in the same WAIT cycle
        fetch_en = 1;
        step();
        redirect = 1; redirect_pc = 16'h0200; imem_ack = 1; imem_rdata = 16'hBEEF;
        step();
        check("f5_novalid", instr_valid, 0);
        check("f5_ir_keep", ir_out, 16'h1111);
        check("f5_pcnxt", pc_next, 16'h0200);
        check("f5_idle", busy, 0);

        // Timeout: 15 WAIT cycles without ack
        fetch_en = 1;
        step();
        fetch_en = 1; // ignored in WAIT
        repeat (14) step();
        check("f6_still_wait", busy, 1);
        check("f6_no_err_yet", fetch_err, 0);
        step();
        check("f6_err", fetch_err, 1);
        check("f6_req_lo", imem_req, 0);
        check("f6_pcnxt", pc_next, 16'h0200);
        step();
        check("f6_err_sticky", fetch_err, 1);
        fetch_en = 1;
        step();
        check("f6_err_clr", fetch_err, 0);
        check("f6_addr", imem_addr, 16'h0200);
        imem_ack = 1; imem_rdata = 16'h2222;
        step();
        check("f6_valid", instr_valid, 1);
        check("f6_ir", ir_out, 16'h2222);
        check("f6_pcnxt", pc_next, 16'h0201);

        // Reset in the middle of WAIT
        fetch_en = 1;
        step();
        step();
        rst = 1;
        #1;
        check("f7_req_async", imem_req, 0);
        step();
        rst = 0;
        check_reset_vals("f7_rst");
        step();
        imem_ack = 1; imem_rdata = 16'h9999;
        step();
        check_reset_vals("f7_late_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
